cpu6_shifter: RTL

Iterative multi-cycle shift unit for the cpu6 execute stage, consuming the `shft_en` / `shft_lr` / `shft_la` controls produced by the ALU decoder. It executes SLL/SLLI/SRL/SRLI/SRA/SRAI by shifting a captured operand a fixed number of bit positions per cycle. It stalls the pipeline while busy and presents a one-cycle `done` strobe with the result. It replaces a 32-bit barrel shifter to save area.

---
 rtl/cpu6_shifter_if.sv | 37 +++
 rtl/cpu6_shifter.sv | 111 +++++++++++
 2 files changed

// File: rtl/cpu6_shifter_if.sv
// Request/response bundle between the cpu6 execute stage and the iterative shifter.
// The master drives the decoded shift request; the slave returns stall/done/result.
interface cpu6_shifter_if;
    logic        shft_en;
    logic        shft_lr;
    logic        shft_la;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    modport master (
        output shft_en,
        output shft_lr,
        output shft_la,
        output a,
        output shamt,
        output flush,
        input  stall,
        input  done,
        input  result
    );

    modport slave (
        input  shft_en,
        input  shft_lr,
        input  shft_la,
        input  a,
        input  shamt,
        input  flush,
        output stall,
        output done,
        output result
    );
endinterface

// File: rtl/cpu6_shifter.sv
// Iterative 32-bit SLL/SRL/SRA unit for the cpu6 execute stage.
// Define CPU6_SHFT_FAST_EN to step up to 4 bits per cycle instead of 1.
module cpu6_shifter (
    input  logic           clk,
    input  logic           reset,
    cpu6_shifter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;
    logic [31:0] result_q;
    logic        lr_q;
    logic        la_q;
    logic        sign_q;

    logic [2:0]  step;
    logic        fill;
    logic [31:0] acc_shifted;

    function automatic logic [31:0] shift_step(logic [31:0] v, logic [2:0] s, logic right,
                                               logic f);
        logic [31:0] r;
        r = v;
        if (right) begin
            unique case (s)
                3'd1:    r = {f, v[31:1]};
                3'd2:    r = {{2{f}}, v[31:2]};
                3'd3:    r = {{3{f}}, v[31:3]};
                3'd4:    r = {{4{f}}, v[31:4]};
                default: r = v;
            endcase
        end else begin
            unique case (s)
                3'd1:    r = {v[30:0], 1'b0};
                3'd2:    r = {v[29:0], 2'b0};
                3'd3:    r = {v[28:0], 3'b0};
                3'd4:    r = {v[27:0], 4'b0};
                default: r = v;
            endcase
        end
        return r;
    endfunction

`ifdef CPU6_SHFT_FAST_EN
    assign step = (cnt_q > 5'd4) ? 3'd4 : cnt_q[2:0];
`else
    assign step = 3'd1;
`endif

    // Only an arithmetic right shift replicates the captured sign bit.
    assign fill        = lr_q & la_q & sign_q;
    assign acc_shifted = shift_step(acc_q, step, lr_q, fill);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            acc_q    <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            lr_q     <= 1'b0;
            la_q     <= 1'b0;
            sign_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.shft_en) begin
                        acc_q  <= bus.a;
                        cnt_q  <= bus.shamt;
                        lr_q   <= bus.shft_lr;
                        la_q   <= bus.shft_la;
                        sign_q <= bus.a[31];
                        if (bus.shamt == 5'd0) begin
                            state_q  <= StDone;
                            result_q <= bus.a;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    acc_q <= acc_shifted;
                    cnt_q <= cnt_q - {2'b00, step};
                    // result is loaded on entry to DONE so it equals acc there and holds after.
                    if (cnt_q == {2'b00, step}) begin
                        state_q  <= StDone;
                        result_q <= acc_shifted;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.stall = 1'b0;
        bus.done  = 1'b0;
        if (!reset && !bus.flush) begin
            bus.stall = ((state_q == StIdle) && bus.shft_en) || (state_q == StShift);
            bus.done  = (state_q == StDone);
        end
    end

    assign bus.result = result_q;

endmodule
